// File: rtl/screen_rom_pkg.sv
// Shared constants, arbiter state and in-flight tag type for the screen ROM arbiter.
package screen_rom_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int IMG_WORDS  = 117750;
    localparam int STARVE_MAX = 4;

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
        logic oor;
    } tag_t;
endpackage

// File: rtl/rom_tag_pipe.sv
// Two-stage tag shift register matching the address-register plus ROM-register latency.
module rom_tag_pipe
    import screen_rom_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vld,
    input  logic i_id,
    input  logic i_oor,
    output logic o_vld,
    output logic o_id,
    output logic o_oor
);
    tag_t [2:1] vld_pipe_q, vld_pipe_d;

    always_comb begin
        vld_pipe_d[1] = '{vld: i_vld, id: i_id, oor: i_oor};
        vld_pipe_d[2] = vld_pipe_q[1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_pipe_q <= '0;
        else          vld_pipe_q <= vld_pipe_d;
    end

    assign o_vld = vld_pipe_q[2].vld;
    assign o_id  = vld_pipe_q[2].id;
    assign o_oor = vld_pipe_q[2].oor;
endmodule

// File: rtl/screen_rom_arbiter.sv
// Two-requester arbiter in front of a synchronous single-port pixel ROM.
// Define ARB_STARVE_GUARD_EN to let requester 1 win after STARVE_MAX consecutive denials.
module screen_rom_arbiter
    import screen_rom_pkg::*;
#(
    parameter int ADDR_W     = screen_rom_pkg::ADDR_W,
    parameter int DATA_W     = screen_rom_pkg::DATA_W,
    parameter int IMG_WORDS  = screen_rom_pkg::IMG_WORDS,
    parameter int STARVE_MAX = screen_rom_pkg::STARVE_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_addr,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_addr,
    output logic              o_req1_ready,
    output logic              o_rsp0_valid,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_oor_err
);
    if (STARVE_MAX < 1) begin : g_bad_cfg
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_e        state;
    logic              starve1;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oor;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              tag_vld, tag_id, tag_oor;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve1 = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Counts only uninterrupted denials; any gap in req1 valid restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req1_valid || o_req1_ready) starve_cnt_d = '0;
        else if (!starve1)                 starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve_cnt_q <= '0;
        else          starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve1 = 1'b0;
`endif

    // Grant decision is made fresh every cycle; nothing is granted while reset is held.
    always_comb begin
        state = IDLE;
        if (!i_rst_n)                                       state = IDLE;
        else if (i_req1_valid && (starve1 || !i_req0_valid)) state = SERVE1;
        else if (i_req0_valid)                              state = SERVE0;
    end

    assign o_req0_ready = (state == SERVE0);
    assign o_req1_ready = (state == SERVE1);
    assign gnt_addr     = (state == SERVE1) ? i_req1_addr : i_req0_addr;
    assign gnt_oor      = (32'(gnt_addr) >= 32'(IMG_WORDS));

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (state != IDLE) rom_addr_d = gnt_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rom_addr_q <= '0;
        else          rom_addr_q <= rom_addr_d;
    end

    assign o_rom_addr = rom_addr_q;

    rom_tag_pipe u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (state != IDLE),
        .i_id    (state == SERVE1),
        .i_oor   (gnt_oor),
        .o_vld   (tag_vld),
        .o_id    (tag_id),
        .o_oor   (tag_oor)
    );

    // Outputs decode straight from the reset-cleared tag so reset zeroes them at once.
    assign o_rsp0_valid = tag_vld && !tag_id;
    assign o_rsp1_valid = tag_vld && tag_id;
    assign o_oor_err    = tag_vld && tag_oor;
    assign o_rsp_data   = (tag_vld && !tag_oor) ? i_rom_data : '0;
endmodule

// File: doc/screen_rom_arbiter.md
SCREEN_ROM_ARBITER -- requirements
Module: screen_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, SHALL be the ROM address width.
REQ-002 Parameter DATA_W, default 8, SHALL be the ROM pixel data width.
REQ-003 Parameter IMG_WORDS, default 117750, SHALL be the count of valid ROM words (471 x 250).
REQ-004 Parameter STARVE_MAX, default 4, SHALL be the consecutive-denial limit for requester 1.
REQ-005 i_clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-006 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_req0_valid / i_req0_addr  in  1 / ADDR_W  SHALL be the requester-0 (VGA pixel fetch) read request.
REQ-008 o_req0_ready  out  1  SHALL indicate that requester 0 is granted this cycle.
REQ-009 i_req1_valid / i_req1_addr  in  1 / ADDR_W  SHALL be the requester-1 (tile/game logic) read request.
REQ-010 o_req1_ready  out  1  SHALL indicate that requester 1 is granted this cycle.
REQ-011 o_rsp0_valid / o_rsp1_valid  out  1  SHALL mark returned data for the given requester.
REQ-012 o_rsp_data  out  DATA_W  SHALL carry returned pixel data, shared by both requesters.
REQ-013 o_rom_addr  out  ADDR_W  SHALL drive the synchronous single-port ROM address.
REQ-014 i_rom_data  in  DATA_W  SHALL be the ROM output, registered one clock after the address is sampled.
REQ-015 o_oor_err  out  1  SHALL pulse for one cycle when a granted address is >= IMG_WORDS.

Function
REQ-016 A transfer SHALL occur in cycle c when valid and ready are both high; ready SHALL be combinational from valid and arbiter state.
REQ-017 At most one ready SHALL be high per cycle; the ROM SHALL accept one read per cycle with no bubbles.
REQ-018 Default priority SHALL be requester 0 over requester 1.
REQ-019 o_rom_addr SHALL be registered and loaded with the granted address at the end of cycle c; when nothing is granted, it SHALL hold its value.
REQ-020 A 2-deep tag pipeline (valid, requester id, oor flag) SHALL track in-flight reads.
REQ-021 o_rspN_valid SHALL assert in cycle c+2 for a grant in cycle c; o_rsp_data SHALL equal i_rom_data in that cycle.
REQ-022 Responses SHALL have no backpressure and SHALL return in grant order.
REQ-023 A granted address >= IMG_WORDS SHALL still be issued; its response SHALL have o_rsp_data = 0 and o_oor_err high in cycle c+2.
REQ-024 When both requesters are idle, o_rsp*_valid SHALL be 0 two cycles later and o_rsp_data SHALL be 0.
REQ-025 The arbiter FSM SHALL have states IDLE (no valid), SERVE0 (req0 granted), SERVE1 (req1 granted), evaluated every cycle from the current valids.

Reset
REQ-026 Asserting i_rst_n low SHALL asynchronously clear o_rom_addr, the tag pipeline, the starvation counter, all rsp valids, o_rsp_data and o_oor_err to 0, and return the FSM to IDLE.
REQ-027 Reads in flight at reset SHALL be dropped with no response; the first grant after release SHALL occur no earlier than the first rising edge with i_rst_n high.

Configuration
REQ-028 With ARB_STARVE_GUARD_EN defined, a saturating counter SHALL count consecutive cycles with i_req1_valid high and not granted; on reaching STARVE_MAX, requester 1 SHALL win the next cycle, and the counter SHALL clear on any requester-1 grant or when i_req1_valid is low.
REQ-029 Without ARB_STARVE_GUARD_EN, priority SHALL be strictly fixed to requester 0 and the counter logic SHALL be absent.

Structure
REQ-030 Package screen_rom_pkg SHALL hold the ADDR_W, DATA_W and IMG_WORDS constants and the FSM state enum {IDLE, SERVE0, SERVE1}.
REQ-031 One sub-module, rom_tag_pipe (the 2-stage tag/valid shift register), SHALL be instantiated; all other logic SHALL be inline.

Verification
REQ-032 Requester 0 only, address 0x00010 (ROM word = 0xA5) -> o_req0_ready in cycle c, o_rom_addr = 0x00010 in c+1, o_rsp0_valid with o_rsp_data = 0xA5 in c+2.
REQ-033 Both requesters valid continuously, guard off -> requester 1 never granted; guard on with STARVE_MAX = 4 -> requester 1 granted in cycle 5, then the pattern repeats.
REQ-034 Back-to-back requester-0 addresses 0..9 -> ten consecutive o_rsp0_valid cycles with in-order data and no gaps.
REQ-035 Requester 1 address 117750 -> response 0x00 plus a single o_oor_err pulse in c+2; address 117749 -> real data and no error.
REQ-036 i_rst_n asserted in cycle c+1 after a grant in cycle c -> no o_rsp valid appears and all outputs are 0 immediately, without waiting for a clock edge.
